// File: rtl/cnt_seq_checker.sv
// Sequence checker for a 4-bit up counter: locks onto +1 steps,
// flags breaks, and cascades rollovers into an 8-bit count.
module cnt_seq_checker (
  input  logic       clk,
  input  logic       re,
  input  logic [3:0] c,
  output logic       locked,
  output logic       wrap,
  output logic [3:0] hi,
  output logic [7:0] cnt8,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCK,
    ERR
  } state_t;

  state_t     state;
  logic [3:0] prev;
  logic [3:0] nxt;
  logic       step;
  logic       roll;

  assign nxt  = prev + 4'd1;
  assign step = (c == nxt);
  assign roll = (prev == 4'hf) && (c == 4'h0);
  assign cnt8 = {hi, prev};

  always_ff @(posedge clk) begin
    if (!re) begin
      state   <= IDLE;
      prev    <= 4'h0;
      locked  <= 1'b0;
      wrap    <= 1'b0;
      hi      <= 4'h0;
      err     <= 1'b0;
      err_cnt <= 4'h0;
    end else begin
      prev <= c;
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          state  <= SYNC;
          locked <= 1'b0;
        end
        SYNC: begin
          if (step) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else begin
            locked <= 1'b0;
          end
        end
        LOCK, ERR: begin
          if (step) begin
            state  <= LOCK;
            locked <= 1'b1;
            // rollover only counts while tracking a valid sequence
            if (roll) begin
              wrap <= 1'b1;
              hi   <= hi + 4'd1;
            end
          end else begin
            state  <= ERR;
            locked <= 1'b0;
            err    <= 1'b1;
            if (err_cnt != 4'hf) begin
              err_cnt <= err_cnt + 4'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker with hand-computed expectations.
module tb_cnt_seq_checker;

  logic       clk;
  logic       re;
  logic [3:0] c;
  logic       locked;
  logic       wrap;
  logic [3:0] hi;
  logic [7:0] cnt8;
  logic       err;
  logic [3:0] err_cnt;

  int n_chk;
  int n_pass;

  cnt_seq_checker dut (
    .clk    (clk),
    .re     (re),
    .c      (c),
    .locked (locked),
    .wrap   (wrap),
    .hi     (hi),
    .cnt8   (cnt8),
    .err    (err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic stp(input logic [3:0] v);
    @(negedge clk);
    re = 1'b1;
    c  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rst(input logic [3:0] v);
    @(negedge clk);
    re = 1'b0;
    c  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 8'(locked), 8'h0);
    chk({tag, "_wrap"}, 8'(wrap), 8'h0);
    chk({tag, "_hi"}, 8'(hi), 8'h0);
    chk({tag, "_cnt8"}, cnt8, 8'h00);
    chk({tag, "_err"}, 8'(err), 8'h0);
    chk({tag, "_errcnt"}, 8'(err_cnt), 8'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    re     = 1'b0;
    c      = 4'h0;

    rst(4'h7);
    rst(4'h9);
    chk_zero("reset");

    // count-up lock
    stp(4'h0);
    chk("up_e1_locked", 8'(locked), 8'h0);
    stp(4'h1);
    chk("up_e2_locked", 8'(locked), 8'h1);
    stp(4'h2);
    chk("up_e3_locked", 8'(locked), 8'h1);
    chk("up_e3_err", 8'(err), 8'h0);
    for (int i = 3; i <= 15; i++) stp(4'(i));
    chk("pre_wrap", 8'(wrap), 8'h0);
    chk("pre_cnt8", cnt8, 8'h0f);
    stp(4'h0);
    chk("wrap_pulse", 8'(wrap), 8'h1);
    chk("wrap_hi", 8'(hi), 8'h1);
    chk("wrap_cnt8", cnt8, 8'h10);
    stp(4'h1);
    chk("wrap_end", 8'(wrap), 8'h0);
    chk("post_cnt8", cnt8, 8'h11);

    // skip 6 -> 9
    for (int i = 2; i <= 6; i++) stp(4'(i));
    chk("seq_ok_err", 8'(err), 8'h0);
    stp(4'h9);
    chk("skip_err", 8'(err), 8'h1);
    chk("skip_errcnt", 8'(err_cnt), 8'h1);
    chk("skip_locked", 8'(locked), 8'h0);
    stp(4'ha);
    chk("relock_locked", 8'(locked), 8'h1);
    chk("relock_err", 8'(err), 8'h1);
    chk("relock_errcnt", 8'(err_cnt), 8'h1);

    // constant c: 20 mismatches, saturate
    for (int i = 0; i < 3; i++) stp(4'h3);
    chk("sat_mid", 8'(err_cnt), 8'h4);
    for (int i = 3; i < 20; i++) stp(4'h3);
    chk("sat_errcnt", 8'(err_cnt), 8'hf);
    chk("sat_locked", 8'(locked), 8'h0);
    chk("sat_err", 8'(err), 8'h1);

    // build hi=3, err_cnt=2 then reset once
    rst(4'h0);
    stp(4'h0);
    stp(4'h1);
    for (int i = 2; i <= 48; i++) stp(4'(i % 16));
    chk("build_hi", 8'(hi), 8'h3);
    stp(4'h5);
    stp(4'h9);
    stp(4'ha);
    chk("build_errcnt", 8'(err_cnt), 8'h2);
    chk("build_locked", 8'(locked), 8'h1);
    rst(4'hb);
    chk_zero("midrst");
    stp(4'h0);
    stp(4'h1);
    chk("rl_locked", 8'(locked), 8'h1);
    chk("rl_err", 8'(err), 8'h0);

    // reset beats a same-cycle rollover
    for (int i = 2; i <= 15; i++) stp(4'(i));
    rst(4'h0);
    chk("rstwrap_wrap", 8'(wrap), 8'h0);
    chk("rstwrap_hi", 8'(hi), 8'h0);

    // rollover seen while in SYNC
    stp(4'h0);
    stp(4'hf);
    chk("sync_mis_locked", 8'(locked), 8'h0);
    chk("sync_mis_err", 8'(err), 8'h0);
    stp(4'h0);
    chk("sync_roll_locked", 8'(locked), 8'h1);
    chk("sync_roll_wrap", 8'(wrap), 8'h0);
    chk("sync_roll_hi", 8'(hi), 8'h0);

    // upstream reset mid-stream while locked
    stp(4'h1);
    stp(4'h2);
    stp(4'h0);
    chk("ureset_err", 8'(err), 8'h1);
    chk("ureset_locked", 8'(locked), 8'h0);
    chk("ureset_errcnt", 8'(err_cnt), 8'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
